// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32 core types, constants and helpers
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - single-entry valid/ready instruction buffer toward decode
// Flush wins over a same-cycle load; free_o says a new load can land next cycle.
module fetch_buf
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            err_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic            free_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_four_o,
  output logic            err_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
      err_d   = err_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign valid_o   = valid_q;
  assign free_o    = !valid_q || ready_i;
  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc_four_o = pc_q + XLEN'(4);
  assign err_o     = err_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - RV32 fetch PC sequencer and single-outstanding imem handshake
// Defining FETCH_PERF_CNT_EN adds a saturating stall counter with synchronous clear.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef FETCH_PERF_CNT_EN
  input  logic              stall_cnt_clr_i,
  output logic [PERF_W-1:0] stall_cnt_o,
`endif
  input  logic              en_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [XLEN-1:0]   imem_rdata_i,
  input  logic              imem_err_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   instr_pc_o,
  output logic [XLEN-1:0]   instr_pc_four_o,
  output logic              instr_err_o,
  output logic              misalign_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            misalign_q, misalign_d;
  logic            buf_free;
  logic            gnt_ok;
  logic            load;

  // Request is held off while the buffer is still occupied so a response can never overwrite it.
  assign imem_req_o  = (state_q == REQ) && buf_free;
  assign imem_addr_o = fetch_pc_q;
  assign gnt_ok      = imem_req_o && imem_gnt_i;
  assign load        = (state_q == WAIT) && imem_rvalid_i && !redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    case (state_q)
      IDLE: if (en_i && buf_free) state_d = REQ;
      REQ:  if (gnt_ok) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid_i) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = en_i ? REQ : IDLE;
        end
      end
      KILL: if (imem_rvalid_i) state_d = en_i ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      if (gnt_ok || ((state_q == WAIT || state_q == KILL) && !imem_rvalid_i)) begin
        state_d = KILL;
      end else begin
        state_d = en_i ? REQ : IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(BOOT_ADDR);
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;

  fetch_buf u_fetch_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (redirect_i),
    .load_i    (load),
    .instr_i   (imem_rdata_i),
    .pc_i      (fetch_pc_q),
    .err_i     (imem_err_i),
    .ready_i   (instr_ready_i),
    .valid_o   (instr_valid_o),
    .free_o    (buf_free),
    .instr_o   (instr_o),
    .pc_o      (instr_pc_o),
    .pc_four_o (instr_pc_four_o),
    .err_o     (instr_err_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (((imem_req_o && !imem_gnt_i) || state_q == KILL) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl: directed table, reset sequence, random traffic
module tb_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_err_i = 1'b0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_four_o;
  logic        instr_err_o;
  logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
  logic        stall_cnt_clr_i = 1'b0;
  logic [31:0] stall_cnt_o;
`endif

  fetch_ctrl #(.BOOT_ADDR(32'h0000_0100)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt_clr_i (stall_cnt_clr_i),
    .stall_cnt_o     (stall_cnt_o),
`endif
    .en_i            (en_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .imem_err_i      (imem_err_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_pc_four_o (instr_pc_four_o),
    .instr_err_o     (instr_err_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return a[5:2] == 4'hA;
  endfunction

  typedef struct {
    logic        en, rdy, gnt, rv, err, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        ierr, mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, rdy, gnt, rv, err, redir, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] pc, input logic ierr, mis);
    vec_t v;
    v = '{en, rdy, gnt, rv, err, redir, rpc, req, addr, valid, pc, ierr, mis};
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [31:0] pc, instr;
    logic        err;
  } item_t;

  item_t       pend[$];
  logic        out_v, out_kill, exp_mis;
  logic [31:0] out_addr, exp_addr, gnt_addr;
  int          age, delivered;

  initial begin
    // en rdy gnt rv err redir rpc | req addr valid pc ierr mis
    add(1,1,0,0,0,0,32'h0,          0,32'h100,0,32'h0,0,0);        // c0 IDLE
    add(1,1,1,0,0,0,32'h0,          1,32'h100,0,32'h0,0,0);
    add(1,1,0,1,0,0,32'h0,          0,32'h100,0,32'h0,0,0);
    for (int k = 0; k < 5; k++)
      add(1,0,0,0,0,0,32'h0,        0,32'h104,1,32'h100,0,0);      // c3-c7 backpressure
    add(1,1,1,0,0,0,32'h0,          1,32'h104,1,32'h100,0,0);      // c8 ready rises
    add(1,1,0,1,0,1,32'h200,        0,32'h104,0,32'h0,0,0);        // c9 redirect + rvalid
    add(1,1,1,0,0,0,32'h0,          1,32'h200,0,32'h0,0,0);
    add(1,1,0,1,0,0,32'h0,          0,32'h200,0,32'h0,0,0);
    add(1,1,1,0,0,0,32'h0,          1,32'h204,1,32'h200,0,0);
    add(1,1,0,1,0,0,32'h0,          0,32'h204,0,32'h0,0,0);
    add(1,1,1,0,0,1,32'h300,        1,32'h208,1,32'h204,0,0);      // c14 redirect in gnt cycle
    add(1,1,0,1,0,0,32'h0,          0,32'h300,0,32'h0,0,0);        // c15 KILL drops response
    add(1,1,1,0,0,0,32'h0,          1,32'h300,0,32'h0,0,0);
    add(1,1,0,1,1,0,32'h0,          0,32'h300,0,32'h0,0,0);        // c17 bus error
    add(1,1,0,0,0,1,32'h402,        1,32'h304,1,32'h300,1,0);      // c18 misaligned redirect
    add(1,1,1,0,0,0,32'h0,          1,32'h400,0,32'h0,0,1);
    add(1,1,0,1,0,0,32'h0,          0,32'h400,0,32'h0,0,0);
    add(1,1,0,0,0,1,32'hFFFF_FFFC,  1,32'h404,1,32'h400,0,0);
    add(1,1,1,0,0,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,0,0);
    add(1,1,0,1,0,0,32'h0,          0,32'hFFFF_FFFC,0,32'h0,0,0);
    add(0,1,1,0,0,0,32'h0,          1,32'h0,1,32'hFFFF_FFFC,0,0);  // c24 wrap, en drops
    add(0,1,0,1,0,0,32'h0,          0,32'h0,0,32'h0,0,0);
    add(0,1,0,0,0,0,32'h0,          0,32'h4,1,32'h0,0,0);
    add(0,1,0,0,0,0,32'h0,          0,32'h4,0,32'h0,0,0);
    add(1,1,0,0,0,0,32'h0,          0,32'h4,0,32'h0,0,0);
    add(1,1,1,0,0,0,32'h0,          1,32'h4,0,32'h0,0,0);
    add(1,1,0,0,0,0,32'h0,          0,32'h4,0,32'h0,0,0);          // c30 WAIT

    repeat (2) @(posedge clk_i);
    #2;
    chk1 ("rst_req", imem_req_o, 1'b0);
    chk32("rst_addr", imem_addr_o, 32'h100);
    chk1 ("rst_valid", instr_valid_o, 1'b0);
    chk32("rst_instr", instr_o, 32'h0);
    chk32("rst_pc", instr_pc_o, 32'h0);
    chk32("rst_pc_four", instr_pc_four_o, 32'h4);
    chk1 ("rst_err", instr_err_o, 1'b0);
    chk1 ("rst_misalign", misalign_o, 1'b0);

    gnt_addr = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk_i);
      #1;
      rst_ni        = 1'b1;
      en_i          = tbl[i].en;
      instr_ready_i = tbl[i].rdy;
      imem_gnt_i    = tbl[i].gnt;
      imem_rvalid_i = tbl[i].rv;
      imem_rdata_i  = tbl[i].rv ? mem_fn(gnt_addr) : 32'h0;
      imem_err_i    = tbl[i].rv & tbl[i].err;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      if (tbl[i].gnt) gnt_addr = tbl[i].addr;
      #1;
      chk1 ($sformatf("row%0d_req", i), imem_req_o, tbl[i].req);
      chk32($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk1 ($sformatf("row%0d_valid", i), instr_valid_o, tbl[i].valid);
      chk1 ($sformatf("row%0d_misalign", i), misalign_o, tbl[i].mis);
      if (tbl[i].valid) begin
        chk32($sformatf("row%0d_pc", i), instr_pc_o, tbl[i].pc);
        chk32($sformatf("row%0d_pc_four", i), instr_pc_four_o, tbl[i].pc + 32'd4);
        chk32($sformatf("row%0d_instr", i), instr_o, mem_fn(tbl[i].pc));
        chk1 ($sformatf("row%0d_err", i), instr_err_o, tbl[i].ierr);
      end
    end

    // Reset while WAIT is outstanding, then a late response lands in IDLE.
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk1 ("midrst_req", imem_req_o, 1'b0);
    chk32("midrst_addr", imem_addr_o, 32'h100);
    chk1 ("midrst_valid", instr_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    en_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk1 ("late_rv_req", imem_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    imem_rvalid_i = 1'b0;
    #1;
    chk1 ("late_rv_valid", instr_valid_o, 1'b0);
    chk1 ("postrst_req", imem_req_o, 1'b1);
    chk32("postrst_addr", imem_addr_o, 32'h100);

    // Random traffic against a transaction-level model.
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    out_v = 1'b0;
    out_kill = 1'b0;
    out_addr = '0;
    exp_addr = 32'h100;
    exp_mis = 1'b0;
    age = 0;
    delivered = 0;
    pend.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_i);
      #1;
      en_i          = ($urandom_range(0, 7) != 0);
      instr_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 11) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 4095));
      imem_rvalid_i = out_v && (age >= 1) && ($urandom_range(0, 1) == 1);
      imem_rdata_i  = imem_rvalid_i ? mem_fn(out_addr) : 32'h0;
      imem_err_i    = imem_rvalid_i && err_fn(out_addr);
      imem_gnt_i    = 1'b0;
      #1;
      if (imem_req_o) begin
        chk1("rand_req_while_outstanding", out_v, 1'b0);
        imem_gnt_i = ($urandom_range(0, 2) != 0);
      end
      #1;
      chk1("rand_valid", instr_valid_o, pend.size() != 0);
      if (instr_valid_o && pend.size() != 0) begin
        chk32("rand_pc", instr_pc_o, pend[0].pc);
        chk32("rand_pc_four", instr_pc_four_o, pend[0].pc + 32'd4);
        chk32("rand_instr", instr_o, pend[0].instr);
        chk1 ("rand_err", instr_err_o, pend[0].err);
      end
      chk1("rand_misalign", misalign_o, exp_mis);
      if (imem_req_o && imem_gnt_i) chk32("rand_gnt_addr", imem_addr_o, exp_addr);

      if (instr_valid_o && instr_ready_i && pend.size() != 0) void'(pend.pop_front());
      if (imem_rvalid_i) begin
        if (!out_kill && !redirect_i) begin
          pend.push_back('{out_addr, mem_fn(out_addr), err_fn(out_addr)});
          exp_addr = out_addr + 32'd4;
          delivered++;
        end
        out_v = 1'b0;
      end
      if (imem_req_o && imem_gnt_i) begin
        out_v = 1'b1;
        out_kill = 1'b0;
        out_addr = exp_addr;
        age = 0;
      end
      if (redirect_i) begin
        pend.delete();
        exp_addr = {redirect_pc_i[31:2], 2'b00};
        if (out_v) out_kill = 1'b1;
      end
      exp_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
      age++;
    end
    chk1("rand_progress", delivered > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
